// File: rtl/axi_bus_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one AXI master port.
// Single outstanding transaction. Define AXI_ARB_RR_EN for round-robin data/inst arbitration.
module axi_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    // instruction fetch requester
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_valid,
    output logic [DATA_W-1:0]   inst_rdata,
    // load/store requester
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    // AXI read channels
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    input  logic                rlast,
    output logic                rready,
    // AXI write channels
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

    state_e              state_q;
    logic                owner_q;   // 1: data requester owns the transaction
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                aw_done_q;
    logic                w_done_q;

    logic idle, data_win, inst_win;
    logic aw_fin, w_fin, r_done, data_rd_ok;

    assign idle = (state_q == StIdle) && aresetn;

`ifdef AXI_ARB_RR_EN
    logic ptr_q;   // 1: inst is favoured on the next contended grant
    assign data_win = idle && data_req && (!inst_req || !ptr_q);
`else
    assign data_win = idle && data_req;
`endif
    assign inst_win = idle && inst_req && !data_win;

    assign inst_addr_ok = inst_win;
    assign data_addr_ok = data_win;

    assign arvalid = (state_q == StAr);
    assign araddr  = addr_q;
    assign rready  = (state_q == StR);
    assign awvalid = (state_q == StAwW) && !aw_done_q;
    assign wvalid  = (state_q == StAwW) && !w_done_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = (state_q == StB);

    // A handshake counts whether it happened earlier or in this very cycle.
    assign aw_fin = aw_done_q || (awvalid && awready);
    assign w_fin  = w_done_q || (wvalid && wready);

    // Completions are gated by reset so an abandoned transaction never reports back.
    assign r_done       = (state_q == StR) && rvalid && rlast && aresetn;
    assign inst_valid   = r_done && !owner_q;
    assign data_rd_ok   = r_done && owner_q;
    assign inst_rdata   = inst_valid ? rdata : '0;
    assign data_rdata   = data_rd_ok ? rdata : '0;
    assign data_data_ok = data_rd_ok || ((state_q == StB) && bvalid && aresetn);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI_ARB_RR_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (data_win) begin
                        owner_q <= 1'b1;
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        wstrb_q <= data_wstrb;
                        state_q <= data_wr ? StAwW : StAr;
                    end else if (inst_win) begin
                        owner_q <= 1'b0;
                        addr_q  <= inst_addr;
                        state_q <= StAr;
                    end
`ifdef AXI_ARB_RR_EN
                    if (data_win || inst_win) begin
                        ptr_q <= data_win;
                    end
`endif
                end
                StAr: begin
                    if (arready) begin
                        state_q <= StR;
                    end
                end
                StR: begin
                    if (rvalid && rlast) begin
                        state_q <= StIdle;
                    end
                end
                StAwW: begin
                    if (aw_fin && w_fin) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= StB;
                    end else begin
                        aw_done_q <= aw_fin;
                        w_done_q  <= w_fin;
                    end
                end
                StB: begin
                    if (bvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/axi_bus_arbiter.md
AXI_BUS_ARBITER -- requirements
Module: axi_bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of the requester and AXI address buses.
REQ-002 Parameter: DATA_W, default 32, data width; write strobe width is DATA_W/8.
REQ-003 aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 inst_req  in  1  instruction-fetch read request, held until granted.
REQ-006 inst_addr  in  ADDR_W  fetch address.
REQ-007 inst_addr_ok  out  1  one-cycle grant pulse to the fetch requester.
REQ-008 inst_valid  out  1  one-cycle fetch-data-return pulse.
REQ-009 inst_rdata  out  DATA_W  fetch data, valid with inst_valid.
REQ-010 data_req / data_wr  in  1/1  load/store request, held until granted; data_wr=1 means write.
REQ-011 data_addr / data_wdata / data_wstrb  in  ADDR_W/DATA_W/DATA_W/8  data request payload.
REQ-012 data_addr_ok  out  1  one-cycle grant pulse to the data requester.
REQ-013 data_data_ok  out  1  one-cycle completion pulse (read data returned or write response received).
REQ-014 data_rdata  out  DATA_W  load data, valid with data_data_ok on reads.
REQ-015 araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI read address channel.
REQ-016 rdata/rvalid/rlast/rready  in/in/in/out  DATA_W/1/1/1  AXI read data channel.
REQ-017 awaddr/awvalid/awready, wdata/wstrb/wvalid/wready  AXI write address/data channels (outputs except the readys).
REQ-018 bvalid/bready  in/out  1/1  AXI write response channel.

Function
REQ-019 Single outstanding transaction; FSM states IDLE, AR, R, AW_W, B.
REQ-020 In IDLE, grant is combinational: the winning requester's addr_ok is high in the same cycle as its req; the FSM moves to AR (read) or AW_W (write) and the payload is latched at that edge.
REQ-021 Fixed priority: data write > data read > inst fetch; at most one addr_ok high per cycle; no grant outside IDLE.
REQ-022 AR: arvalid=1 with latched address from the first cycle after grant; held stable until arready; then move to R.
REQ-023 R: rready=1; on rvalid&rlast, pulse the owner's valid/data_ok with rdata for exactly that cycle, then return to IDLE; rvalid without rlast is ignored.
REQ-024 AW_W: awvalid and wvalid asserted together; each deasserts after its own handshake; move to B once both handshakes have occurred, in either order or in the same cycle.
REQ-025 B: bready=1; on bvalid, pulse data_data_ok for one cycle and return to IDLE.
REQ-026 inst_rdata and data_rdata are zero except in their valid cycle.
REQ-027 Best-case latency: grant cycle n, arvalid in n+1; arready in n+1 and rvalid&rlast in n+2 give valid in n+2 and a new grant possible in n+3.
REQ-028 A request dropped before grant is lost silently; the latched payload is unaffected by input changes after grant.

Reset
REQ-029 While aresetn=0 at a clock edge: FSM goes to IDLE, write handshake flags clear, and the RR pointer clears; after reset, all valid, addr_ok and data_ok outputs are 0, rready=0 and bready=0.
REQ-030 Reset mid-transaction abandons it with no completion pulse; the first grant is possible in the first cycle with aresetn=1.

Configuration
REQ-031 With AXI_ARB_RR_EN defined: data vs inst arbitration is round-robin; a 1-bit pointer toggles to favour the other class after each grant; data write still precedes data read.
REQ-032 Without AXI_ARB_RR_EN: the fixed priority of REQ-021 applies and no pointer exists.

Verification
REQ-033 inst_req=1, addr 0x1C000000, arready one cycle later, rdata 0x02C00000 with rlast -> inst_addr_ok in the request cycle, araddr=0x1C000000, inst_valid one pulse with 0x02C00000.
REQ-034 data_req=1 write, addr 0x80, wdata 0xDEADBEEF, wstrb 0xF; wready 2 cycles before awready; bvalid 1 cycle later -> awvalid/wvalid each drop after their own handshake, data_data_ok one pulse on bvalid.
REQ-035 inst_req and data_req (read) together in the same cycle -> data granted first, inst granted in the first IDLE cycle after the data completes; with AXI_ARB_RR_EN and the pointer favouring inst, inst is granted first.
REQ-036 arready held 0 for 5 cycles -> arvalid stays 1 and araddr stays stable; no second grant occurs.
REQ-037 aresetn=0 during state R -> next cycle IDLE, all outputs 0; a later rvalid produces no valid pulse.
